microcode_rom_loader: RTL and testbench

- Writer side of the CPU control unit's microcode ROM.
- Accepts the microcode image as a byte stream using a valid/ready handshake.
- Packs each 8 bytes into one 64-bit control word, byte 0 into bits [63:56], matching the control unit's word layout, and issues sequential writes from address 0.
- Sits between the boot/serial front end and the control-store write port, so microcode can be reloaded without a simulator-side file load.

---
 rtl/microcode_rom_loader_if.sv | 11 +
 rtl/microcode_rom_loader.sv | 177 +++++++++++++++++
 tb/tb_microcode_rom_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_rom_loader_if.sv
// Byte-stream handshake carrying the microcode image into the loader.
// master = image source (boot/serial front end), slave = loader.
interface microcode_rom_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);
endinterface

// File: rtl/microcode_rom_loader.sv
// Packs a microcode byte stream into control words and writes them sequentially from address 0.
// Optional checksum checking is enabled by defining MICROCODE_LOADER_CHECKSUM_EN.
module microcode_rom_loader #(
  parameter int ADDR_W     = 12,
  parameter int WORD_BYTES = 8
) (
  input  logic                      clk,
  input  logic                      r,
  input  logic                      start,
  microcode_rom_loader_if.slave     bs,
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  input  logic [7:0]                expected_sum,
  output logic                      err_checksum,
  output logic [7:0]                checksum,
`endif
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [8*WORD_BYTES-1:0]   wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err_partial,
  output logic                      err_overflow,
  output logic [ADDR_W:0]           words_written
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_partial_q, err_partial_d;
  logic                err_overflow_q, err_overflow_d;
  logic [ADDR_W:0]     words_q, words_d;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                err_checksum_q, err_checksum_d;
`endif

  logic                accept;
  logic [WORD_W-1:0]   word_merged;

  assign accept = (state_q == S_LOAD) && bs.byte_valid;

  // Accumulator with the incoming byte dropped into its lane; byte 0 lands in the MSBs.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    assign word_merged[WORD_W-1-8*gi -: 8] =
      (idx_q == IDX_W'(gi)) ? bs.byte_data : acc_q[WORD_W-1-8*gi -: 8];
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    addr_d         = addr_q;
    acc_d          = acc_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    done_d         = done_q;
    err_partial_d  = err_partial_q;
    err_overflow_d = err_overflow_q;
    words_d        = words_q;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
    err_checksum_d = err_checksum_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          acc_d = word_merged;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
          sum_d = sum_q + bs.byte_data;
`endif
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word_merged;
            words_d   = words_q + 1'b1;
            // The top address is never wrapped past; overflow ends the load there.
            if (addr_q != TOP_ADDR) addr_d = addr_q + 1'b1;
            if (bs.byte_last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
              if (sum_d != expected_sum) err_checksum_d = 1'b1;
`endif
            end else if (addr_q == TOP_ADDR) begin
              state_d        = S_ERROR;
              err_overflow_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            if (bs.byte_last) begin
              state_d       = S_ERROR;
              err_partial_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d        = S_LOAD;
          idx_d          = '0;
          addr_d         = '0;
          acc_d          = '0;
          done_d         = 1'b0;
          err_partial_d  = 1'b0;
          err_overflow_d = 1'b0;
          words_d        = '0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
          sum_d          = '0;
          err_checksum_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      addr_q         <= '0;
      acc_q          <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      done_q         <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      words_q        <= '0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q          <= '0;
      err_checksum_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      addr_q         <= addr_d;
      acc_q          <= acc_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      done_q         <= done_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
      words_q        <= words_d;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
      err_checksum_q <= err_checksum_d;
`endif
    end
  end

  assign bs.byte_ready   = (state_q == S_LOAD);
  assign busy            = (state_q == S_LOAD);
  assign wr_en           = wr_en_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign done            = done_q;
  assign err_partial     = err_partial_q;
  assign err_overflow    = err_overflow_q;
  assign words_written   = words_q;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  assign err_checksum    = err_checksum_q;
  assign checksum        = sum_q;
`endif
endmodule

// File: tb/tb_microcode_rom_loader.sv
// Vector-table bench for microcode_rom_loader using a 4-word control store (ADDR_W=2).
// Checksum sequence is included when MICROCODE_LOADER_CHECKSUM_EN is defined.
module tb_microcode_rom_loader;
  localparam int AW = 2;
  localparam int OW = 71 + 2 * AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          r;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          busy, done, err_partial, err_overflow;
  logic [AW:0]   words_written;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  logic [7:0]    expected_sum;
  logic          err_checksum;
  logic [7:0]    checksum;
`endif

  microcode_rom_loader_if bs ();

  microcode_rom_loader #(.ADDR_W(AW), .WORD_BYTES(8)) dut (
    .clk          (clk),
    .r            (r),
    .start        (start),
    .bs           (bs),
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    .expected_sum (expected_sum),
    .err_checksum (err_checksum),
    .checksum     (checksum),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .words_written(words_written)
  );

  typedef struct {
    logic          rst;
    logic          st;
    logic          v;
    logic [7:0]    d;
    logic          l;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [OW-1:0] obs;
  assign obs = {bs.byte_ready, wr_en, wr_addr, wr_data, busy, done,
                err_partial, err_overflow, words_written};

  // One line per control-store write.
  always @(negedge clk) begin
    if (wr_en) $display("write addr %0d data %h words %0d", wr_addr, wr_data, words_written);
  end

  function automatic logic [63:0] mkword(input logic [7:0] b);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = b + 8'(k);
    return w;
  endfunction

  // Expected output record; busy always equals byte_ready.
  function automatic logic [OW-1:0] ex(input logic rdy, input logic we, input logic [AW-1:0] a,
                                       input logic [63:0] d, input logic dn, input logic ep,
                                       input logic eo, input logic [AW:0] w);
    return {rdy, we, a, d, rdy, dn, ep, eo, w};
  endfunction

  task automatic push(input logic rs, input logic st, input logic v, input logic [7:0] d,
                      input logic l, input logic [OW-1:0] e);
    vec_t x;
    x.rst = rs; x.st = st; x.v = v; x.d = d; x.l = l; x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic rs, input logic st, input logic v, input logic [7:0] d,
                       input logic l);
    @(negedge clk);
    r             = rs;
    start         = st;
    bs.byte_valid = v;
    bs.byte_data  = d;
    bs.byte_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int tag, input logic [OW-1:0] want);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL vec %0d outputs: got %h want %h", tag, obs, want);
    end
  endtask

  logic [63:0] w0, w1, w3;

  initial begin
    r = 1'b1; start = 1'b0;
    bs.byte_valid = 1'b0; bs.byte_data = '0; bs.byte_last = 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    expected_sum = 8'h78;
`endif
    w0 = mkword(8'h00);
    w1 = mkword(8'h08);
    w3 = mkword(8'h10);

    // Test 1: reset, start, 16 bytes back to back, last on 0x0F.
    push(1, 0, 0, 8'h00, 0, ex(0, 0, '0, '0, 0, 0, 0, '0));
    push(0, 1, 0, 8'h00, 0, ex(1, 0, '0, '0, 0, 0, 0, '0));
    for (int i = 0; i < 16; i++) begin
      int n;
      n = i + 1;
      push(0, 0, 1, 8'(i), i == 15,
           ex(n < 16, (n % 8) == 0, AW'(n >= 16 ? 1 : 0), n < 8 ? 64'h0 : (n < 16 ? w0 : w1),
              n == 16, 0, 0, (AW+1)'(n / 8)));
    end
    push(0, 0, 0, 8'h00, 0, ex(0, 0, AW'(1), w1, 1, 0, 0, (AW+1)'(2)));

    // Test 2: same image, byte_valid every other cycle, junk on idle cycles.
    push(0, 1, 0, 8'h00, 0, ex(1, 0, AW'(1), w1, 0, 0, 0, '0));
    begin
      int n;
      n = 0;
      for (int j = 0; j < 32; j++) begin
        logic v;
        v = (j % 2) == 0;
        if (v) n++;
        push(0, 0, v, v ? 8'(n - 1) : 8'hEE, v && (n == 16),
             ex(n < 16, v && ((n % 8) == 0), AW'(n < 8 ? 1 : (n < 16 ? 0 : 1)),
                n < 8 ? w1 : (n < 16 ? w0 : w1), n == 16, 0, 0, (AW+1)'(n / 8)));
      end
    end

    // Test 3: 11 bytes, last on the 11th -> partial error.
    push(0, 1, 0, 8'h00, 0, ex(1, 0, AW'(1), w1, 0, 0, 0, '0));
    for (int i = 0; i < 11; i++) begin
      int n;
      n = i + 1;
      push(0, 0, 1, 8'(16 + i), i == 10,
           ex(n < 11, n == 8, AW'(n < 8 ? 1 : 0), n < 8 ? w1 : w3, 0, n == 11, 0,
              (AW+1)'(n >= 8 ? 1 : 0)));
    end
    for (int i = 0; i < 2; i++) push(0, 0, 1, 8'hAA, 1, ex(0, 0, '0, w3, 0, 1, 0, (AW+1)'(1)));

    // Test 4: 40 bytes with no last into a 4-word store -> overflow after 32.
    push(0, 1, 0, 8'h00, 0, ex(1, 0, '0, w3, 0, 0, 0, '0));
    for (int i = 0; i < 40; i++) begin
      int n;
      n = (i < 32) ? i + 1 : 32;
      push(0, 0, 1, 8'(i), 0,
           ex(n < 32, (i < 32) && ((n % 8) == 0), AW'(n < 8 ? 0 : n / 8 - 1),
              n < 8 ? w3 : mkword(8'(8 * (n / 8 - 1))), 0, 0, n == 32, (AW+1)'(n / 8)));
    end

    // Test 4b: exactly full image, last on the 32nd byte -> done, no error.
    push(0, 1, 0, 8'h00, 0, ex(1, 0, AW'(3), mkword(8'h18), 0, 0, 0, '0));
    for (int i = 0; i < 32; i++) begin
      int n;
      n = i + 1;
      push(0, 0, 1, 8'(64 + i), i == 31,
           ex(n < 32, (n % 8) == 0, AW'(n < 8 ? 3 : n / 8 - 1),
              n < 8 ? mkword(8'h18) : mkword(8'(64 + 8 * (n / 8 - 1))),
              n == 32, 0, 0, (AW+1)'(n / 8)));
    end

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].st, vecs[k].v, vecs[k].d, vecs[k].l);
      check(k, vecs[k].exp);
    end

    // Test 5: reset asserted partway through the second word aborts the load.
    drive(1, 0, 0, 8'h00, 0);
    check(1000, ex(0, 0, '0, '0, 0, 0, 0, '0));
    drive(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 8'(8'h80 + i), 0);
    check(1001, ex(1, 1, '0, mkword(8'h80), 0, 0, 0, (AW+1)'(1)));
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'(8'h88 + i), 0);
    drive(1, 0, 1, 8'h8D, 0);
    check(1002, ex(0, 0, '0, '0, 0, 0, 0, '0));
    drive(0, 0, 1, 8'h8E, 0);
    check(1003, ex(0, 0, '0, '0, 0, 0, 0, '0));
    drive(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 8'(8'h90 + i), 0);
    check(1004, ex(1, 0, '0, '0, 0, 0, 0, '0));
    drive(0, 0, 1, 8'h97, 0);
    check(1005, ex(1, 1, '0, mkword(8'h90), 0, 0, 0, (AW+1)'(1)));

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    // Test 6: checksum of bytes 0x00..0x0F is 0x78.
    drive(1, 0, 0, 8'h00, 0);
    n_vec++;
    if ({err_checksum, checksum} !== 9'h000) begin
      n_bad++;
      $display("FAIL vec 2000 checksum reset: got %b/%h want 0/00", err_checksum, checksum);
    end
    for (int pass = 0; pass < 2; pass++) begin
      logic [9:0] got, want;
      expected_sum = (pass == 0) ? 8'h78 : 8'h77;
      drive(0, 1, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 8'(i), i == 15);
      got  = {done, err_checksum, checksum};
      want = {1'b1, pass == 1, 8'h78};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL vec %0d checksum done/err/sum: got %h want %h", 2001 + pass, got, want);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
